call_return_sequencer: RTL and testbench
========================================

Name: call_return_sequencer

Overview:
- Multi-cycle controller that sequences CALL and RETURN through the shared data-memory port and commits PC, SP and RA updates to the register state.
- Sits between decode and the single data-memory port.
- Stalls the fetch path (busy) while a stack access is outstanding.
- Replaces the combinational RETURN path, which assumed zero-latency memory.

Parameters:
- ADDR_W, 16, width of PC/SP/RA and memory address
- DATA_W, 16, memory data width
- IMM_W, 10, width of signed frame-adjust immediate

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request from decode; sampled only in IDLE
- op  in  1  0 = RETURN, 1 = CALL
- immediate  in  IMM_W  signed frame adjust, in 16-bit words
- target  in  ADDR_W  CALL destination PC
- pcIn, spIn, raIn  in  ADDR_W  current architectural PC/SP/RA
- mem_req  out  1  memory access valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  stack address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid when mem_ready is high
- mem_ready  in  1  access completes this cycle
- busy  out  1  stall fetch/decode
- pc_we, sp_we, ra_we  out  1  one-cycle commit strobes
- pcOut, spOut, raOut  out  ADDR_W  commit values
- done  out  1  one-cycle completion pulse
- fault  out  1  alignment fault pulse (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; operand registers 0.
- Immediate: immx = sext(immediate) << 1. All arithmetic is modulo 2^ADDR_W, wrapping silently.
- States: IDLE, RET_LOAD, CALL_STORE, COMMIT.
- IDLE
  - If start: latch op, immx, target, pcIn, spIn, raIn.
  - Go to RET_LOAD if op = 0, else CALL_STORE.
  - busy = 0 in IDLE.
- RET_LOAD
  - mem_req = 1, mem_we = 0, mem_addr = sp_l.
  - On mem_ready: capture mem_rdata into rdata_l, then go to COMMIT.
- CALL_STORE
  - mem_req = 1, mem_we = 1, mem_addr = sp_l - 2, mem_wdata = ra_l.
  - On mem_ready, go to COMMIT.
- Memory handshake
  - mem_req, mem_we, mem_addr and mem_wdata are driven from state and latched registers only.
  - They stay stable until mem_ready.
  - mem_ready while mem_req = 0 is ignored.
- COMMIT (exactly one cycle)
  - pc_we = sp_we = ra_we = done = 1, then return to IDLE.
  - RETURN commits: pcOut = ra_l; spOut = sp_l + immx; raOut = rdata_l.
  - CALL commits: pcOut = target_l; spOut = sp_l - 2 + immx; raOut = pc_l + 2.
- busy is 1 in every state except IDLE, including the COMMIT cycle.
- Latency with zero-wait memory: start accepted at edge N; mem_req high in cycle N+1; COMMIT in N+2. Each wait cycle adds 1.
- start while busy is ignored and not queued. Decode must hold the instruction under busy.
- Reset mid-operation: return to IDLE at once, mem_req drops asynchronously, no commit strobe is issued.
- Outside COMMIT, pcOut, spOut and raOut hold 0.

Optional Feature:
- Macro: SEQ_STACK_ALIGN_CHECK_EN.
- Defined: in IDLE, if start and the effective access address is odd, go to COMMIT with no memory access.
  - Effective address is spIn for RETURN, spIn - 2 for CALL.
  - In that COMMIT: pc_we = sp_we = ra_we = 0, done = 1, fault = 1.
- Undefined: no check; odd addresses go to memory unchanged; fault is tied 0.

Decomposition:
- Package unicycle_seq_pkg:
  - state enum (IDLE, RET_LOAD, CALL_STORE, COMMIT)
  - OP_RETURN = 0, OP_CALL = 1
  - STACK_WORD_BYTES = 2
  - function sext_imm_x2(imm)
- Sub-module sp_adjust: combinational sp_l + immx and sp_l - 2 + immx.

Test Plan:
- RETURN, zero-wait memory
  - Stimulus: sp = 0x1000, ra = 0x0200, imm = 0x004, mem[0x1000] = 0xABCD.
  - Required: read at 0x1000; commit in cycle N+2 with pcOut = 0x0200, spOut = 0x1008, raOut = 0xABCD.
- CALL, 3 wait cycles
  - Stimulus: pc = 0x0040, sp = 0x1000, ra = 0x0100, target = 0x0300, imm = 0x3FE (-2).
  - Required: write 0x0100 to 0x0FFE with addr/data held 4 cycles; commit pcOut = 0x0300, spOut = 0x0FFA, raOut = 0x0042.
- Wrap-around
  - Stimulus: CALL with sp = 0x0000, imm = 0.
  - Required: write to 0xFFFE; spOut = 0xFFFE.
- start pulsed during busy
  - Required: ignored; exactly one done pulse.
- rst_n asserted during RET_LOAD wait
  - Required: mem_req drops asynchronously; no pc_we/sp_we/ra_we pulses; IDLE after release.
- With SEQ_STACK_ALIGN_CHECK_EN defined
  - Stimulus: RETURN with sp = 0x1001.
  - Required: no mem_req; done = fault = 1 for one cycle; no write enables.

Source files
------------

// File: rtl/unicycle_seq_pkg.sv
// Shared types and helpers for the CALL/RETURN stack sequencer.
package unicycle_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RET_LOAD,
    CALL_STORE,
    COMMIT
  } seq_state_t;

  localparam logic        OP_RETURN        = 1'b0;
  localparam logic        OP_CALL          = 1'b1;
  localparam int unsigned STACK_WORD_BYTES = 2;

  // Sign-extend an imm_w-bit word count and scale it to a byte offset.
  function automatic logic [31:0] sext_imm_x2(input logic [31:0] imm,
                                              input int unsigned imm_w);
    logic signed [31:0] s;
    s = signed'(imm << (32 - imm_w));
    s = s >>> (32 - imm_w);
    return 32'(s <<< 1);
  endfunction

endpackage

// File: rtl/call_return_sequencer_sp_adjust.sv
// Stack pointer arithmetic for the sequencer: push address and committed SP.
module sp_adjust
  import unicycle_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] sp_l,
  input  logic [ADDR_W-1:0] immx,
  output logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] sp_ret,
  output logic [ADDR_W-1:0] sp_call
);

  always_comb begin
    push_addr = sp_l - ADDR_W'(STACK_WORD_BYTES);
    sp_ret    = sp_l + immx;
    sp_call   = push_addr + immx;
  end

endmodule

// File: rtl/call_return_sequencer.sv
// Multi-cycle CALL/RETURN sequencer over the shared data-memory port.
// Optional stack alignment fault: define SEQ_STACK_ALIGN_CHECK_EN.
module call_return_sequencer
  import unicycle_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] pcIn,
  input  logic [ADDR_W-1:0] spIn,
  input  logic [ADDR_W-1:0] raIn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              pc_we,
  output logic              sp_we,
  output logic              ra_we,
  output logic [ADDR_W-1:0] pcOut,
  output logic [ADDR_W-1:0] spOut,
  output logic [ADDR_W-1:0] raOut,
  output logic              done,
  output logic              fault
);

  seq_state_t        state, state_n;
  logic              op_l;
  logic              fault_l;
  logic              align_fault;
  logic [ADDR_W-1:0] immx_l, target_l, pc_l, sp_l, ra_l;
  logic [DATA_W-1:0] rdata_l;
  logic [ADDR_W-1:0] push_addr, sp_ret, sp_call;

`ifdef SEQ_STACK_ALIGN_CHECK_EN
  // CALL accesses spIn - 2, which has the same parity as spIn.
  assign align_fault = spIn[0];
`else
  assign align_fault = 1'b0;
`endif

  sp_adjust #(.ADDR_W(ADDR_W)) u_sp_adjust (
    .sp_l      (sp_l),
    .immx      (immx_l),
    .push_addr (push_addr),
    .sp_ret    (sp_ret),
    .sp_call   (sp_call)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_l     <= 1'b0;
      fault_l  <= 1'b0;
      immx_l   <= '0;
      target_l <= '0;
      pc_l     <= '0;
      sp_l     <= '0;
      ra_l     <= '0;
      rdata_l  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        op_l     <= op;
        fault_l  <= align_fault;
        immx_l   <= ADDR_W'(sext_imm_x2(32'(immediate), IMM_W));
        target_l <= target;
        pc_l     <= pcIn;
        sp_l     <= spIn;
        ra_l     <= raIn;
      end
      if (state == RET_LOAD && mem_ready) begin
        rdata_l <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    pc_we     = 1'b0;
    sp_we     = 1'b0;
    ra_we     = 1'b0;
    pcOut     = '0;
    spOut     = '0;
    raOut     = '0;
    done      = 1'b0;
    fault     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (align_fault)            state_n = COMMIT;
          else if (op == OP_RETURN)   state_n = RET_LOAD;
          else                        state_n = CALL_STORE;
        end
      end
      RET_LOAD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = sp_l;
        if (mem_ready) state_n = COMMIT;
      end
      CALL_STORE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = push_addr;
        mem_wdata = DATA_W'(ra_l);
        if (mem_ready) state_n = COMMIT;
      end
      COMMIT: begin
        busy    = 1'b1;
        done    = 1'b1;
        fault   = fault_l;
        state_n = IDLE;
        if (!fault_l) begin
          pc_we = 1'b1;
          sp_we = 1'b1;
          ra_we = 1'b1;
          if (op_l == OP_CALL) begin
            pcOut = target_l;
            spOut = sp_call;
            raOut = pc_l + ADDR_W'(STACK_WORD_BYTES);
          end else begin
            pcOut = ra_l;
            spOut = sp_ret;
            raOut = ADDR_W'(rdata_l);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_call_return_sequencer.sv
// Randomized bench for call_return_sequencer against a stack/memory reference model.
module tb_call_return_sequencer;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [IW-1:0] immediate = '0;
  logic [AW-1:0] target = '0, pcIn = '0, spIn = '0, raIn = '0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy, pc_we, sp_we, ra_we, done, fault;
  logic [AW-1:0] pcOut, spOut, raOut;

  call_return_sequencer #(.ADDR_W(AW), .DATA_W(DW), .IMM_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .immediate(immediate),
    .target(target), .pcIn(pcIn), .spIn(spIn), .raIn(raIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
    .pc_we(pc_we), .sp_we(sp_we), .ra_we(ra_we),
    .pcOut(pcOut), .spOut(spOut), .raOut(raOut), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

`ifdef SEQ_STACK_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_seen = 0, we_seen = 0, exp_done = 0, exp_we = 0;
  logic [15:0] mem_model [logic [15:0]];

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    if ((pc_we | sp_we | ra_we) === 1'b1) we_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    op        = 1'($urandom);
    immediate = IW'($urandom);
    target    = AW'($urandom);
    pcIn      = AW'($urandom);
    spIn      = AW'($urandom);
    raIn      = AW'($urandom);
  endtask

  task automatic run_op(input bit is_call, input logic [9:0] imm, input logic [15:0] tgt,
                        input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] ra,
                        input int waits);
    int          words;
    logic [15:0] immx, addr, exp_pc, exp_sp, exp_ra, rdat;
    bit          fault_exp;
    words = imm[9] ? int'(imm) - 1024 : int'(imm);
    immx  = 16'(words * 2);
    addr  = is_call ? sp - 16'd2 : sp;
    fault_exp = ALIGN_EN && addr[0];
    rdat = '0;
    if (is_call) begin
      exp_pc = tgt;
      exp_sp = sp - 16'd2 + immx;
      exp_ra = pc + 16'd2;
    end else begin
      rdat   = mem_model.exists(addr) ? mem_model[addr] : 16'($urandom);
      exp_pc = ra;
      exp_sp = sp + immx;
      exp_ra = rdat;
    end

    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    op = is_call; immediate = imm; target = tgt; pcIn = pc; spIn = sp; raIn = ra;
    start = 1'b1;
    mem_ready = 1'($urandom);
    mem_rdata = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b0;
    if (!fault_exp) begin
      for (int w = 0; w <= waits; w++) begin
        check_eq("mem_req", mem_req, 1);
        check_eq("mem_we", mem_we, is_call);
        check_eq("mem_addr", mem_addr, addr);
        if (is_call) check_eq("mem_wdata", mem_wdata, ra);
        check_eq("busy_wait", busy, 1);
        check_eq("no_early_we", pc_we, 0);
        mem_ready = (w == waits);
        mem_rdata = (w == waits) ? rdat : 16'($urandom);
        start = 1'($urandom);
        scramble_inputs();
        @(negedge clk);
      end
      mem_ready = 1'b0;
      if (is_call) mem_model[addr] = ra;
    end
    start = 1'b0;
    check_eq("commit_done", done, 1);
    check_eq("commit_busy", busy, 1);
    check_eq("commit_fault", fault, fault_exp);
    check_eq("commit_pc_we", pc_we, !fault_exp);
    check_eq("commit_sp_we", sp_we, !fault_exp);
    check_eq("commit_ra_we", ra_we, !fault_exp);
    check_eq("commit_mem_req", mem_req, 0);
    if (!fault_exp) begin
      check_eq("pcOut", pcOut, exp_pc);
      check_eq("spOut", spOut, exp_sp);
      check_eq("raOut", raOut, exp_ra);
      exp_we++;
    end
    exp_done++;
    mem_ready = 1'($urandom);
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("post_done", done, 0);
    check_eq("post_busy", busy, 0);
    check_eq("post_pcOut", pcOut, 0);
    check_eq("post_spOut", spOut, 0);
    check_eq("post_raOut", raOut, 0);
    check_eq("post_mem_req", mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    mem_model[16'h1000] = 16'hABCD;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pc_we", pc_we, 0);
    check_eq("rst_pcOut", pcOut, 0);
    rst_n = 1'b1;

    run_op(1'b0, 10'h004, 16'h0000, 16'h0000, 16'h1000, 16'h0200, 0);
    run_op(1'b1, 10'h3FE, 16'h0300, 16'h0040, 16'h1000, 16'h0100, 3);
    run_op(1'b1, 10'h000, 16'h1234, 16'h0010, 16'h0000, 16'h0777, 1);
    run_op(1'b0, 10'h001, 16'h0000, 16'h0000, 16'h1001, 16'h0456, 0);

    // Reset during an outstanding RETURN load.
    @(negedge clk);
    op = 1'b0; spIn = 16'h2000; raIn = 16'h0abc; immediate = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("rst_mid_req", mem_req, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_req", mem_req, 0);
    check_eq("rst_async_busy", busy, 0);
    check_eq("rst_async_we", pc_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release_busy", busy, 0);
    check_eq("rst_release_req", mem_req, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), 10'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    check_eq("done_count", done_seen, exp_done);
    check_eq("we_count", we_seen, exp_we);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
